// File: rtl/barret_3187_arbiter.sv
// Round-robin sharing of one mod-3187 Barrett reducer among N_REQ requesters,
// with an operand register in front of the reducer and a result register behind it.

module barret_for_3187 (
  input  logic [22:0] din_a,
  output logic [11:0] dout_r
);
  // m = floor(2^24 / 3187); the quotient estimate is at most one short, so one correction suffices
  localparam logic [12:0] M = 13'd5264;

  logic [35:0] prod;
  logic [11:0] q_est;
  logic [22:0] q_mul;
  logic [12:0] r_raw;

  assign prod   = 36'(din_a) * 36'(M);
  assign q_est  = prod[35:24];
  assign q_mul  = 23'(24'(q_est) * 24'd3187);
  assign r_raw  = 13'(din_a - q_mul);
  assign dout_r = (r_raw >= 13'd3187) ? 12'(r_raw - 13'd3187) : r_raw[11:0];
endmodule

module barret_3187_arbiter #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [23*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  rsp_valid,
  output logic [11:0]           rsp_data,
  output logic [ID_W-1:0]       rsp_id,
  input  logic                  rsp_ready,
  output logic                  busy,
  output logic [31:0]           done_cnt
);
  logic [N_REQ-1:0][22:0] req_ops;
  logic [ID_W-1:0]        ptr;
  logic [ID_W-1:0]        winner;
  logic                   grant_found;
  int                     idx;

  logic [22:0]     s1_data;
  logic [ID_W-1:0] s1_id;
  logic            s1_valid;
  logic [11:0]     red_out;

  logic s2_free, s1_free, s1_move, accept, rsp_fire;

  assign req_ops  = req_data;
  assign s2_free  = !rsp_valid | rsp_ready;
  assign s1_free  = !s1_valid | s2_free;
  assign s1_move  = s1_valid & s2_free;
  assign rsp_fire = rsp_valid & rsp_ready;
  assign accept   = |req_ready;
  assign busy     = s1_valid | rsp_valid;

  // Scan starts one past the last grant, so the most recent winner has lowest priority
  always_comb begin
    grant_found = 1'b0;
    winner      = '0;
    idx         = 0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = (int'(ptr) + off) % N_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        winner      = ID_W'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_found && s1_free && rst_n) req_ready[winner] = 1'b1;
  end

  barret_for_3187 u_red (
    .din_a  (s1_data),
    .dout_r (red_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= ID_W'(N_REQ - 1);
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_id    <= '0;
    end else if (accept) begin
      ptr      <= winner;
      s1_valid <= 1'b1;
      s1_data  <= req_ops[winner];
      s1_id    <= winner;
    end else if (s1_move) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      done_cnt  <= '0;
    end else begin
      if (s1_move) begin
        rsp_valid <= 1'b1;
        rsp_data  <= red_out;
        rsp_id    <= s1_id;
      end else if (rsp_fire) begin
        rsp_valid <= 1'b0;
      end
      if (rsp_fire) done_cnt <= done_cnt + 32'd1;
    end
  end
endmodule
